// File: rtl/wm8978_pkg.sv
// Shared types and constants for the WM8978 control-port I2C target.
package wm8978_pkg;

    localparam logic [6:0] WM8978_ADDR = 7'h1a;
    localparam int         REG_W       = 9;
    localparam int         RADDR_W     = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEV_ADDR,
        ST_DEV_ACK,
        ST_BYTE1,
        ST_ACK1,
        ST_BYTE2,
        ST_ACK2,
        ST_IGNORE
    } state_t;

    // Byte phase that follows each ACK slot; after ACK2 a new {reg, data} pair starts.
    function automatic state_t ack_next(input state_t s);
        case (s)
            ST_DEV_ACK: ack_next = ST_BYTE1;
            ST_ACK1:    ack_next = ST_BYTE2;
            ST_ACK2:    ack_next = ST_BYTE1;
            default:    ack_next = ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/wm8978_i2c_slave_if.sv
// Local register-port bundle of the WM8978 I2C target (read port, commit strobe, status).
interface wm8978_i2c_slave_if;
    import wm8978_pkg::*;

    // wr_en is a one-cycle strobe qualifying wr_addr/wr_data; there is no backpressure,
    // so the consumer must take every committed value in the cycle it is strobed.
    logic [RADDR_W-1:0] rd_addr;
    logic [REG_W-1:0]   rd_data;
    logic               wr_en;
    logic [RADDR_W-1:0] wr_addr;
    logic [REG_W-1:0]   wr_data;
    logic               busy;
    logic               addr_err;
    state_t             dbg_state;

    modport slave (
        input  rd_addr,
        output rd_data, wr_en, wr_addr, wr_data, busy, addr_err, dbg_state
    );

    modport master (
        output rd_addr,
        input  rd_data, wr_en, wr_addr, wr_data, busy, addr_err, dbg_state
    );

endinterface

// File: rtl/wm8978_i2c_slave_line_cond.sv
// I2C line conditioner: 2-FF synchronizer, optional stability filter, edge pulses.
// The filter is built only when I2C_GLITCH_FILT_EN is defined.
module i2c_line_cond #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0] sync;
    logic       lvl_c;
    logic       prev;

    // Idle-high bus: synchronizers come out of reset at 1 so no false edge is seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], pin};
        end
    end

`ifdef I2C_GLITCH_FILT_EN
    localparam int CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic             filt;
    logic [CNT_W-1:0] cnt;

    // Output follows the input only after FILT_LEN consecutive cycles at the new level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt <= 1'b1;
            cnt  <= '0;
        end else if (sync[1] == filt) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(FILT_LEN - 1)) begin
            filt <= sync[1];
            cnt  <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign lvl_c = filt;
`else
    logic unused_filt;
    assign unused_filt = (FILT_LEN > 0);
    assign lvl_c       = sync[1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= 1'b1;
        end else begin
            prev <= lvl_c;
        end
    end

    assign level = lvl_c;
    assign rise  = lvl_c & ~prev;
    assign fall  = ~lvl_c & prev;

endmodule

// File: rtl/wm8978_i2c_slave.sv
// WM8978 control-port I2C target: accepts {reg, d8}/{data} write pairs into a 9-bit register file.
// Optional line glitch filter enabled by defining I2C_GLITCH_FILT_EN.
module wm8978_i2c_slave
    import wm8978_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = WM8978_ADDR,
    parameter int         REG_NUM    = 58,
    parameter int         FILT_LEN   = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                scl,
    inout  wire                 sda,
    wm8978_i2c_slave_if.slave   bus
);

    localparam int         IDX_W     = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
    localparam logic [7:0] REG_NUM_L = 8'(REG_NUM);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_cond #(.FILT_LEN(FILT_LEN)) u_scl_cond (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (scl),
        .level (scl_lvl),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_line_cond #(.FILT_LEN(FILT_LEN)) u_sda_cond (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (sda),
        .level (sda_lvl),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    logic start_det, stop_det;
    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;

    state_t              state, state_n;
    logic [2:0]          bit_cnt, bit_cnt_n;
    logic [6:0]          shreg, shreg_n;
    logic [RADDR_W-1:0]  reg_addr, reg_addr_n;
    logic                d8, d8_n;
    logic                sda_oe, sda_oe_n;
    logic                commit, range_err;
    logic [7:0]          byte_in;
    logic                last_bit;
    logic                addr_ok;
    logic [REG_W-1:0]    commit_val;

    assign byte_in    = {shreg, sda_lvl};
    assign last_bit   = (bit_cnt == 3'd7);
    assign addr_ok    = ({1'b0, reg_addr} < REG_NUM_L);
    assign commit_val = {d8, byte_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            reg_addr <= '0;
            d8       <= 1'b0;
            sda_oe   <= 1'b0;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            shreg    <= shreg_n;
            reg_addr <= reg_addr_n;
            d8       <= d8_n;
            sda_oe   <= sda_oe_n;
        end
    end

    // START/STOP override everything; a partial pair is dropped simply by not committing it.
    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        shreg_n    = shreg;
        reg_addr_n = reg_addr;
        d8_n       = d8;
        sda_oe_n   = sda_oe;
        commit     = 1'b0;
        range_err  = 1'b0;
        if (stop_det) begin
            state_n  = ST_IDLE;
            sda_oe_n = 1'b0;
        end else if (start_det) begin
            state_n   = ST_DEV_ADDR;
            bit_cnt_n = '0;
            sda_oe_n  = 1'b0;
        end else begin
            case (state)
                ST_DEV_ADDR, ST_BYTE1, ST_BYTE2: begin
                    if (scl_rise) begin
                        shreg_n   = byte_in[6:0];
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (last_bit) begin
                            if (state == ST_DEV_ADDR) begin
                                state_n = (byte_in == {SLAVE_ADDR, 1'b0}) ? ST_DEV_ACK : ST_IGNORE;
                            end else if (state == ST_BYTE1) begin
                                reg_addr_n = byte_in[7:1];
                                d8_n       = byte_in[0];
                                state_n    = ST_ACK1;
                            end else begin
                                commit    = addr_ok;
                                range_err = ~addr_ok;
                                state_n   = ST_ACK2;
                            end
                        end
                    end
                end
                ST_DEV_ACK, ST_ACK1, ST_ACK2: begin
                    // First falling edge starts the ACK slot, the second one ends it.
                    if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe_n = 1'b1;
                        end else begin
                            sda_oe_n  = 1'b0;
                            bit_cnt_n = '0;
                            state_n   = ack_next(state);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda = sda_oe ? 1'b0 : 1'bz;

    logic [REG_W-1:0] regs [REG_NUM];
    logic [IDX_W-1:0] wr_idx, rd_idx;

    assign wr_idx = reg_addr[IDX_W-1:0];
    assign rd_idx = bus.rd_addr[IDX_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[wr_idx] <= commit_val;
        end
    end

    // Read-during-write returns the old value: the array update lands on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rd_data <= '0;
        end else if ({1'b0, bus.rd_addr} < REG_NUM_L) begin
            bus.rd_data <= regs[rd_idx];
        end else begin
            bus.rd_data <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.wr_en    <= 1'b0;
            bus.wr_addr  <= '0;
            bus.wr_data  <= '0;
            bus.addr_err <= 1'b0;
        end else begin
            bus.wr_en    <= commit;
            bus.addr_err <= range_err;
            if (commit) begin
                bus.wr_addr <= reg_addr;
                bus.wr_data <= commit_val;
            end
        end
    end

    assign bus.busy      = (state != ST_IDLE);
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_wm8978_i2c_slave.sv
// Bench for wm8978_i2c_slave: bit-banged I2C master, frame table, commit scoreboard.
module tb_wm8978_i2c_slave;
    import wm8978_pkg::*;

    localparam int Q = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic m_scl = 1'b1;
    logic m_drv = 1'b0;
    wire  sda;

    always #10 clk = ~clk;

    assign sda = m_drv ? 1'b0 : 1'bz;
    pullup (sda);

    wm8978_i2c_slave_if bus_if ();

    wm8978_i2c_slave dut (
        .clk   (clk),
        .rst_n (rst_n),
        .scl   (m_scl),
        .sda   (sda),
        .bus   (bus_if)
    );

    int total   = 0;
    int bad     = 0;
    int wr_cnt  = 0;
    int err_cnt = 0;
    int dut_low = 0;
    logic wr_prev = 1'b0;
    logic [15:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every wr_en pops one expected {reg, value} pair.
    always @(negedge clk) begin
        if (rst_n && bus_if.wr_en) begin
            wr_cnt++;
            chk("wr_single_cycle", 32'(wr_prev), 32'd0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wr_unexpected: actual=%0h_%0h required=none", bus_if.wr_addr, bus_if.wr_data);
            end else begin
                chk("wr_pair", 32'({bus_if.wr_addr, bus_if.wr_data}), 32'(exp_q.pop_front()));
            end
        end
        if (rst_n && bus_if.addr_err) err_cnt++;
        if (sda === 1'b0 && !m_drv) dut_low++;
        wr_prev = bus_if.wr_en;
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_drv = 1'b0; wq();
        m_scl = 1'b1; wq();
        m_drv = 1'b1; wq();
        m_scl = 1'b0; wq();
    endtask

    task automatic i2c_stop();
        m_drv = 1'b1; wq();
        m_scl = 1'b1; wq();
        m_drv = 1'b0; wq(); wq();
    endtask

    task automatic send_bits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            m_drv = ~b[i]; wq();
            m_scl = 1'b1;  wq(); wq();
            m_scl = 1'b0;  wq();
        end
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        send_bits(b);
        m_drv = 1'b0; wq();
        m_scl = 1'b1; wq();
        ack = (sda === 1'b0);
        wq();
        m_scl = 1'b0; wq();
    endtask

    task automatic read_chk(input string name, input logic [6:0] a, input logic [8:0] exp);
        @(negedge clk) bus_if.rd_addr = a;
        @(negedge clk);
        chk(name, 32'(bus_if.rd_data), 32'(exp));
    endtask

    typedef struct {
        logic [5:0][7:0] b;
        int              nb;
        logic [5:0]      ack;
        logic [6:0]      ca;
        logic [8:0]      cd;
    } vec_t;

    function automatic vec_t mk(input logic [7:0] b0, b1, b2, b3, b4, input int nb,
                                input logic [5:0] ack, input logic [6:0] ca, input logic [8:0] cd);
        vec_t v;
        v.b    = '0;
        v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3; v.b[4] = b4;
        v.nb   = nb;
        v.ack  = ack;
        v.ca   = ca;
        v.cd   = cd;
        return v;
    endfunction

    localparam int NV = 10;
    vec_t vt[NV];

    initial begin
        logic       ack;
        logic [6:0] r;
        logic [8:0] d;
        logic [6:0] ra;
        int         w0, e0, l0, ew, ee, nz;

        vt[0] = mk(8'h34, 8'h07, 8'h00, 8'h00, 8'h00, 2, 6'b000011, 7'd3, 9'h000);
        vt[1] = mk(8'h34, 8'h07, 8'h6f, 8'h00, 8'h00, 3, 6'b000111, 7'd3, 9'h16f);
        vt[2] = mk(8'h36, 8'h07, 8'h6f, 8'h00, 8'h00, 3, 6'b000000, 7'd3, 9'h16f);
        vt[3] = mk(8'h35, 8'h00, 8'h00, 8'h00, 8'h00, 2, 6'b000000, 7'd3, 9'h16f);
        vt[4] = mk(8'h34, 8'h7e, 8'h01, 8'h02, 8'h55, 5, 6'b011111, 7'd1, 9'h055);
        vt[5] = mk(8'h34, 8'h73, 8'h00, 8'h00, 8'h00, 3, 6'b000111, 7'd57, 9'h100);
        vt[6] = mk(8'h34, 8'h74, 8'h12, 8'h00, 8'h00, 3, 6'b000111, 7'd57, 9'h100);
        for (int k = 7; k < 9; k++) begin
            r = 7'($urandom_range(10, 50));
            d = 9'($urandom_range(0, 511));
            vt[k] = mk(8'h34, {r, d[8]}, d[7:0], 8'h00, 8'h00, 3, 6'b000111, r, d);
        end
        vt[9] = mk(8'h34, 8'h10, 8'h11, 8'h13, 8'h22, 5, 6'b011111, 7'd9, 9'h122);

        bus_if.rd_addr = '0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rd_data", 32'(bus_if.rd_data), 32'h0);
        chk("rst_wr_en", 32'(bus_if.wr_en), 32'h0);
        chk("rst_busy", 32'(bus_if.busy), 32'h0);
        chk("rst_addr_err", 32'(bus_if.addr_err), 32'h0);
        chk("rst_sda", 32'(sda), 32'h1);
        chk("rst_state", 32'(bus_if.dbg_state), 32'(ST_IDLE));
        wq();

        for (int k = 0; k < NV; k++) begin
            w0 = wr_cnt; e0 = err_cnt; l0 = dut_low; ew = 0; ee = 0;
            // Expected commits follow from the frame bytes alone.
            if (vt[k].b[0] == {WM8978_ADDR, 1'b0}) begin
                for (int j = 1; j + 1 < vt[k].nb; j += 2) begin
                    ra = vt[k].b[j][7:1];
                    if (ra < 7'd58) begin
                        exp_q.push_back({ra, vt[k].b[j][0], vt[k].b[j+1]});
                        ew++;
                    end else begin
                        ee++;
                    end
                end
            end
            i2c_start();
            chk($sformatf("busy_frame%0d", k), 32'(bus_if.busy), 32'h1);
            for (int j = 0; j < vt[k].nb; j++) begin
                write_byte(vt[k].b[j], ack);
                chk($sformatf("ack_frame%0d_byte%0d", k, j), 32'(ack), 32'(vt[k].ack[j]));
            end
            i2c_stop();
            wq();
            chk($sformatf("idle_frame%0d", k), 32'(bus_if.busy), 32'h0);
            chk($sformatf("wr_count_frame%0d", k), 32'(wr_cnt - w0), 32'(ew));
            chk($sformatf("err_count_frame%0d", k), 32'(err_cnt - e0), 32'(ee));
            if (vt[k].ack == '0) chk($sformatf("no_drive_frame%0d", k), 32'(dut_low - l0), 32'h0);
            read_chk($sformatf("read_frame%0d", k), vt[k].ca, vt[k].cd);
        end

        read_chk("read_reg8", 7'd8, 9'h011);
        read_chk("read_reg3_kept", 7'd3, 9'h16f);
        read_chk("read_oob58", 7'd58, 9'h000);
        read_chk("read_oob127", 7'd127, 9'h000);

        // Repeated START drops the half-sent pair; only the second frame commits.
        w0 = wr_cnt;
        exp_q.push_back({7'd5, 9'h1aa});
        i2c_start();
        write_byte(8'h34, ack);
        write_byte(8'h0b, ack);
        i2c_start();
        write_byte(8'h34, ack);
        write_byte(8'h0b, ack);
        write_byte(8'haa, ack);
        chk("rs_last_ack", 32'(ack), 32'h1);
        i2c_stop();
        wq();
        chk("rs_wr_count", 32'(wr_cnt - w0), 32'h1);
        read_chk("rs_reg5", 7'd5, 9'h1aa);

        // Reset while the device-address ACK is being driven.
        i2c_start();
        send_bits(8'h34);
        m_drv = 1'b0;
        wq();
        chk("ack_held_before_reset", 32'(sda), 32'h0);
        chk("state_dev_ack", 32'(bus_if.dbg_state), 32'(ST_DEV_ACK));
        #3 rst_n = 1'b0;
        #1;
        chk("reset_sda_released", 32'(sda), 32'h1);
        chk("reset_busy", 32'(bus_if.busy), 32'h0);
        wq();
        rst_n = 1'b1;
        i2c_stop();
        nz = 0;
        for (int a = 0; a < 58; a++) begin
            @(negedge clk) bus_if.rd_addr = 7'(a);
            @(negedge clk);
            if (bus_if.rd_data != 9'h000) nz++;
        end
        chk("regs_cleared", 32'(nz), 32'h0);

        w0 = wr_cnt;
        exp_q.push_back({7'd2, 9'h0c3});
        i2c_start();
        write_byte(8'h34, ack);
        chk("post_reset_addr_ack", 32'(ack), 32'h1);
        write_byte(8'h04, ack);
        write_byte(8'hc3, ack);
        chk("post_reset_data_ack", 32'(ack), 32'h1);
        i2c_stop();
        wq();
        chk("post_reset_wr_count", 32'(wr_cnt - w0), 32'h1);
        read_chk("post_reset_reg2", 7'd2, 9'h0c3);
        read_chk("post_reset_reg5", 7'd5, 9'h000);

        chk("exp_q_empty", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
